// File: rtl/bombe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bombe_pkg
// Description : Shared constants, FSM state encodings and position helper
//               for the bombe search sequencer and its debug display.
// Revision    : 1.0 - initial release
// ============================================================================
package bombe_pkg;

  localparam int ROTOR_MAX     = 25;
  localparam int NUM_POSITIONS = 17576;

  // 3-bit encodings are also decoded by the debug LED display
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_STEP   = 3'd4,
    ST_FOUND  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Out-of-range rotor positions (26..31) are loaded as 0
  function automatic logic [4:0] clamp_pos(input logic [4:0] value);
    return (value > 5'(ROTOR_MAX)) ? 5'd0 : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotor_position_counter.sv
`default_nettype none
// ============================================================================
// Module      : rotor_position_counter
// Description : Mod-26 shadow rotor position with clamped load, increment
//               enable and combinational carry (position == 25).
// Revision    : 1.0 - initial release
// ============================================================================
module rotor_position_counter
  import bombe_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [4:0] load_value,
  input  logic       inc,
  output logic [4:0] pos,
  output logic       carry_out
);

  // Carry is asserted while sitting at the last position
  assign carry_out = (pos == 5'(ROTOR_MAX));

  // Position register: load has priority over increment, wrap 25 -> 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos <= 5'd0;
    end else if (load) begin
      pos <= clamp_pos(load_value);
    end else if (inc) begin
      pos <= carry_out ? 5'd0 : pos + 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bombe_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : bombe_step_controller
// Description : Bombe search sequencer. Loads a start position, steps the
//               fast/mid/slow rotors in odometer order, waits for rotor
//               settling and handshakes each position with the menu checker.
// Revision    : 1.0 - initial release
// ============================================================================
module bombe_step_controller
  import bombe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [14:0] init_pos,
  input  logic        start,
  input  logic        check_ack,
  input  logic        check_hit,
  output logic        rotor_load,
  output logic        step_fast,
  output logic        step_mid,
  output logic        step_slow,
  output logic [4:0]  pos_fast,
  output logic [4:0]  pos_mid,
  output logic [4:0]  pos_slow,
  output logic        check_req,
  output logic        busy,
  output logic        found,
  output logic        exhausted,
  output logic [2:0]  state
);

  state_t      cur_state;
  state_t      next_state;
  logic [3:0]  settle_cnt;
  logic [14:0] checked_cnt;
  logic [14:0] checked_inc;
  logic        pos_inc;
  logic        fast_carry;
  logic        mid_carry;
  logic        slow_carry;

  // Saturating next value of the checked-position count
  assign checked_inc = (checked_cnt == 15'(NUM_POSITIONS)) ? checked_cnt
                                                           : checked_cnt + 15'd1;

  // Positions advance at the end of the STEP cycle; a concurrent load
  // replaces the increment with the new start position
  assign pos_inc = (cur_state == ST_STEP) && !load;

  rotor_position_counter u_fast (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_value (init_pos[4:0]),
    .inc        (pos_inc),
    .pos        (pos_fast),
    .carry_out  (fast_carry)
  );

  rotor_position_counter u_mid (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_value (init_pos[9:5]),
    .inc        (pos_inc && fast_carry),
    .pos        (pos_mid),
    .carry_out  (mid_carry)
  );

  rotor_position_counter u_slow (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_value (init_pos[14:10]),
    .inc        (pos_inc && fast_carry && mid_carry),
    .pos        (pos_slow),
    .carry_out  (slow_carry)
  );

  // Slow rotor wraps with no further carry; its carry is intentionally unused
  logic unused_slow_carry;
  assign unused_slow_carry = slow_carry;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic; load overrides everything
  always_comb begin
    next_state = cur_state;
    if (load) begin
      next_state = ST_LOAD;
    end else begin
      case (cur_state)
        ST_IDLE:   if (start) next_state = ST_SETTLE;
        ST_LOAD:   next_state = ST_IDLE;
        ST_SETTLE: if (settle_cnt == 4'(SETTLE_CYCLES - 1)) next_state = ST_CHECK;
        ST_CHECK: begin
          if (check_ack) begin
            if (check_hit)                                  next_state = ST_FOUND;
            else if (checked_inc == 15'(NUM_POSITIONS))     next_state = ST_DONE;
            else                                            next_state = ST_STEP;
          end
        end
        ST_STEP:   next_state = ST_SETTLE;
        ST_FOUND:  if (start) next_state = ST_STEP;
        ST_DONE:   next_state = ST_DONE;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Settle timer runs only while in SETTLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      settle_cnt <= 4'd0;
    end else if (cur_state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + 4'd1;
    end else begin
      settle_cnt <= 4'd0;
    end
  end

  // Count of positions the checker has acknowledged since the last load
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      checked_cnt <= 15'd0;
    end else if (load) begin
      checked_cnt <= 15'd0;
    end else if ((cur_state == ST_CHECK) && check_ack) begin
      checked_cnt <= checked_inc;
    end
  end

  // Registered one-cycle pulses, aligned with the LOAD / STEP state cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rotor_load <= 1'b0;
      step_fast  <= 1'b0;
      step_mid   <= 1'b0;
      step_slow  <= 1'b0;
    end else begin
      rotor_load <= (next_state == ST_LOAD);
      step_fast  <= (next_state == ST_STEP);
      step_mid   <= (next_state == ST_STEP) && fast_carry;
      step_slow  <= (next_state == ST_STEP) && fast_carry && mid_carry;
    end
  end

  assign check_req = (cur_state == ST_CHECK);
  assign found     = (cur_state == ST_FOUND);
  assign exhausted = (cur_state == ST_DONE);
  assign busy      = !((cur_state == ST_IDLE) || (cur_state == ST_FOUND) ||
                       (cur_state == ST_DONE));
  assign state     = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_bombe_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bombe_step_controller
// Description : Directed self-checking bench for bombe_step_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bombe_step_controller;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [14:0] init_pos = 15'd0;
  logic        start = 1'b0;
  logic        check_ack = 1'b0;
  logic        check_hit = 1'b0;
  logic        rotor_load, step_fast, step_mid, step_slow;
  logic [4:0]  pos_fast, pos_mid, pos_slow;
  logic        check_req, busy, found, exhausted;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int n_hs = 0, n_sf = 0, n_sm = 0, n_ss = 0, n_rl = 0;

  bombe_step_controller #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .init_pos   (init_pos),
    .start      (start),
    .check_ack  (check_ack),
    .check_hit  (check_hit),
    .rotor_load (rotor_load),
    .step_fast  (step_fast),
    .step_mid   (step_mid),
    .step_slow  (step_slow),
    .pos_fast   (pos_fast),
    .pos_mid    (pos_mid),
    .pos_slow   (pos_slow),
    .check_req  (check_req),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Event counters for handshakes and pulses
  always @(posedge clk) begin
    if (check_req && check_ack) n_hs <= n_hs + 1;
    if (step_fast)  n_sf <= n_sf + 1;
    if (step_mid)   n_sm <= n_sm + 1;
    if (step_slow)  n_ss <= n_ss + 1;
    if (rotor_load) n_rl <= n_rl + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (!check_req && n < max_cycles) begin
      tick();
      n++;
    end
    check("req_timeout", 32'(check_req), 32'd1);
  endtask

  function automatic logic [25:0] all_outs();
    return {rotor_load, step_fast, step_mid, step_slow, check_req, busy, found,
            exhausted, state, pos_slow, pos_mid, pos_fast};
  endfunction

  initial begin
    int sf0, sm0, ss0, hs0, rl0, guard;

    // Reset state
    tick(); tick();
    check("reset_outs", 32'(all_outs()), 32'd0);
    resetn = 1'b1;
    tick();
    check("idle_after_reset", 32'(state), 32'd0);
    check("no_pulse_after_reset", 32'({rotor_load, step_fast}), 32'd0);

    // Clamped load {31,26,7}
    load = 1'b1; init_pos = {5'd31, 5'd26, 5'd7};
    tick();
    load = 1'b0;
    check("load_state", 32'(state), 32'd1);
    check("load_pulse", 32'(rotor_load), 32'd1);
    check("load_clamp", 32'({pos_slow, pos_mid, pos_fast}), 32'({5'd0, 5'd0, 5'd7}));
    tick();
    check("load_pulse_one_cycle", 32'(rotor_load), 32'd0);
    check("load_to_idle", 32'(state), 32'd0);

    // Load origin, start, hit on 5th ack
    load = 1'b1; init_pos = 15'd0;
    tick();
    load = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("settle_state", 32'(state), 32'd2);
    check("req_not_early", 32'(check_req), 32'd0);
    tick();
    check("start_latency_req", 32'(check_req), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_req(20);
      check("check_pos_fast", 32'(pos_fast), 32'(k));
      check_ack = 1'b1; check_hit = (k == 4);
      tick();
      check_ack = 1'b0; check_hit = 1'b0;
      check("req_drops", 32'(check_req), 32'd0);
      if (k < 4) check("step_after_ack", 32'({state, step_fast}), 32'({3'd4, 1'b1}));
    end
    check("found_flag", 32'({found, busy, state}), 32'({1'b1, 1'b0, 3'd5}));
    check("found_pos", 32'(pos_fast), 32'd4);
    tick();
    check("found_holds", 32'({state, pos_fast}), 32'({3'd5, 5'd4}));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_step", 32'({state, step_fast}), 32'({3'd4, 1'b1}));
    tick(); tick();
    check("resume_req", 32'(check_req), 32'd1);
    check("resume_pos", 32'(pos_fast), 32'd5);

    // Load while in CHECK with ack the same cycle
    load = 1'b1; check_ack = 1'b1; init_pos = {5'd3, 5'd25, 5'd25};
    tick();
    load = 1'b0; check_ack = 1'b0;
    check("load_in_check_state", 32'(state), 32'd1);
    check("load_in_check_no_step", 32'(step_fast), 32'd0);
    check("load_in_check_count", 32'(dut.checked_cnt), 32'd0);
    check("load_in_check_pos", 32'({pos_slow, pos_mid, pos_fast}), 32'({5'd3, 5'd25, 5'd25}));
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req(20);
    check_ack = 1'b1;
    tick();
    check_ack = 1'b0;
    check("triple_carry", 32'({step_fast, step_mid, step_slow}), 32'd7);
    tick();
    check("carry_pos", 32'({pos_slow, pos_mid, pos_fast}), 32'({5'd4, 5'd0, 5'd0}));
    check("carry_pulses_end", 32'({step_fast, step_mid, step_slow}), 32'd0);

    // Asynchronous reset mid-SETTLE
    check("in_settle", 32'(state), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outs", 32'(all_outs()), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    sf0 = n_sf; rl0 = n_rl;
    for (int i = 0; i < 5; i++) tick();
    check("post_reset_idle", 32'(state), 32'd0);
    check("post_reset_no_pulses", 32'((n_sf - sf0) + (n_rl - rl0)), 32'd0);

    // Full search from origin with ack held high and no hit
    load = 1'b1; init_pos = 15'd0;
    tick();
    load = 1'b0;
    tick();
    hs0 = n_hs; sf0 = n_sf; sm0 = n_sm; ss0 = n_ss;
    start = 1'b1; check_ack = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!exhausted && guard < 60000) begin
      tick();
      guard++;
    end
    check("exhaust_reached", 32'(exhausted), 32'd1);
    tick();
    check("exhaust_handshakes", 32'(n_hs - hs0), 32'd17576);
    check("exhaust_step_fast", 32'(n_sf - sf0), 32'd17575);
    check("exhaust_step_mid", 32'(n_sm - sm0), 32'd675);
    check("exhaust_step_slow", 32'(n_ss - ss0), 32'd25);
    check("done_flags", 32'({state, exhausted, busy, check_req}), 32'({3'd6, 1'b1, 1'b0, 1'b0}));
    start = 1'b1;
    tick();
    start = 1'b0; check_ack = 1'b0;
    tick();
    check("done_ignores_start", 32'(state), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
